// File: rtl/sigmon_log_pkg.sv
// Shared types and constants for the sigmon event logger: record layout,
// field widths and the saturation value of the drop counter.
package sigmon_log_pkg;

    localparam int SRC_W  = 2;
    localparam int TS_W   = 32;
    localparam int DATA_W = 48;
    localparam int REC_W  = 96;
    localparam int RSV_W  = REC_W - TS_W - SRC_W - 3 - DATA_W;

    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [SRC_W-1:0]  src;
        logic              match;
        logic              sample;
        logic              merged;
        logic [RSV_W-1:0]  rsvd;
        logic [DATA_W-1:0] data;
    } rec_t;

endpackage

// File: rtl/sigmon_log_fifo.sv
// Single-clock record FIFO with flush; level counts every stored record,
// including the one currently presented on rd_data.
module sigmon_log_fifo
    import sigmon_log_pkg::*;
#(
    parameter int  DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [REC_W-1:0] wr_data,
    input  logic             rd_rdy,
    output logic [REC_W-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign pop     = rd_rdy && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is accepted.
    assign push    = wr_en && (!full || pop);
    assign rd_data = empty ? '0 : mem[rptr_q];

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; rd_data is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr_q] <= wr_data;
    end

endmodule

// File: rtl/sigmon_event_log.sv
// Sigmon event collector: per-source hold registers, fixed-priority arbiter
// into a record FIFO. Macro SIGMON_LOG_TIMESTAMP_EN enables the timestamp counter.
module sigmon_event_log
    import sigmon_log_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int NSRC  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         log_enable,
    input  logic                         log_clear,
    input  logic [NSRC-1:0]              src_match,
    input  logic [NSRC-1:0]              src_sample,
    input  logic [NSRC-1:0]              src_merged,
    input  logic [NSRC-1:0][DATA_W-1:0]  src_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [REC_W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic [15:0]                  drop_count,
    output logic                         overrun
);

    logic [TS_W-1:0] ts_cur;

`ifdef SIGMON_LOG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + TS_W'(1);
    end

    assign ts_cur = ts_q;
`else
    assign ts_cur = '0;
`endif

    rec_t            hold_q [NSRC];
    rec_t            hold_d [NSRC];
    logic [NSRC-1:0] hvld_q, hvld_d;
    logic [NSRC-1:0] ev, grant, drop;
    logic [2:0]      ndrop;
    logic [16:0]     drop_sum;
    logic [15:0]     drop_count_q, drop_count_d;
    logic            overrun_q, overrun_d;
    logic            fifo_full, fifo_empty, fifo_room;
    rec_t            wr_rec;

    assign out_vld    = !fifo_empty;
    assign fifo_room  = !fifo_full || (out_vld && out_rdy);
    assign drop_count = drop_count_q;
    assign overrun    = overrun_q;

    always_comb begin
        ev     = log_enable ? (src_match | src_sample | src_merged) : '0;
        grant  = '0;
        drop   = '0;
        ndrop  = '0;
        hvld_d = hvld_q;
        hold_d = hold_q;
        wr_rec = '0;

        // Lowest index wins; source 0 has absolute priority.
        if (fifo_room) begin
            for (int i = 0; i < NSRC; i++) begin
                if (hvld_q[i] && grant == '0) grant[i] = 1'b1;
            end
        end

        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                wr_rec    = hold_q[i];
                hvld_d[i] = 1'b0;
            end
            if (ev[i]) begin
                if (!hvld_q[i] || grant[i]) begin
                    hvld_d[i]        = 1'b1;
                    hold_d[i].ts     = ts_cur;
                    hold_d[i].src    = SRC_W'(i);
                    hold_d[i].match  = src_match[i];
                    hold_d[i].sample = src_sample[i];
                    hold_d[i].merged = src_merged[i];
                    hold_d[i].rsvd   = '0;
                    hold_d[i].data   = src_sample[i] ? src_data[i] : '0;
                end else begin
                    drop[i] = 1'b1;
                    ndrop   = ndrop + 3'd1;
                end
            end
        end

        drop_sum     = {1'b0, drop_count_q} + {14'd0, ndrop};
        drop_count_d = drop_sum[16] ? DROP_SAT : drop_sum[15:0];
        overrun_d    = overrun_q || (drop != '0);

        if (log_clear) begin
            hvld_d       = '0;
            drop_count_d = '0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hvld_q       <= '0;
            drop_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            hvld_q       <= hvld_d;
            drop_count_q <= drop_count_d;
            overrun_q    <= overrun_d;
        end
    end

    // Hold payloads are qualified by hvld_q, so they need no reset.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    sigmon_log_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (log_clear),
        .wr_en   (grant != '0),
        .wr_data (wr_rec),
        .rd_rdy  (out_rdy),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

endmodule

// File: doc/sigmon_event_log.md
# sigmon_event_log

Sigmon event collector and logger. It consumes the end-of-packet match, sample and merged events plus the 48-bit sampled data produced by up to four pattern units. It timestamps each event, arbitrates simultaneous events into a single FIFO, and drains the FIFO to the host-side reader over a valid/ready stream. It sits between the pattern bank and the sigmon register/DMA readout path, as the consumer end of the pattern units' event interface.

## Interface
- `DEPTH`, 64: FIFO entries; power of two, 4..1024.
- `NSRC`, 4: event sources, fixed at 4 (2-bit source id).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `log_enable`  in  1  level; capture is allowed while high.
- `log_clear`  in  1  single-cycle pulse; flushes all state.
- `src_match`  in  4  per-source match_event (1-cycle pulse).
- `src_sample`  in  4  per-source sample_event (1-cycle pulse).
- `src_merged`  in  4  per-source merged_event (1-cycle pulse).
- `src_data`  in  4x48  per-source sample_data; valid when `src_sample` is high.
- `out_vld`  out  1  record available.
- `out_rdy`  in  1  reader accepts.
- `out_data`  out  96  record.
- `fifo_level`  out  clog2(DEPTH)+1  current occupancy.
- `drop_count`  out  16  events lost; saturating.
- `overrun`  out  1  sticky; set on the first drop.

## Operation
- Event on source i in cycle N: any of match, sample or merged is high for i.
- If `log_enable` is low, the event is ignored and is not counted as a drop.
- Each source has a one-deep hold register storing {timestamp(N), match, sample, merged, data}.
  - data is zero when sample=0.
  - The hold register is loaded in cycle N and shows valid from N+1.
- Arbiter: each cycle, grants the lowest-index valid hold register when the FIFO is not full.
  - The granted record is written to the FIFO and the hold register is cleared.
  - Round-robin is not used.
  - Source 0 is highest priority.
- New event on a source whose hold register is still valid and not granted in the same cycle: the new event is dropped and the old one is kept.
  - `drop_count`+1, `overrun`=1.
- A hold register granted in cycle M may reload from an event in cycle M with no drop.
- Record layout in `out_data`:
  - [95:64] timestamp
  - [63:62] source id
  - [61] match
  - [60] sample
  - [59] merged
  - [58:48] zero
  - [47:0] data
- Timestamp: 32-bit free-running counter, +1 every cycle, wraps 0xFFFFFFFF→0. It is not stopped by `log_enable`.
- Output: standard valid/ready handshake.
  - `out_data` is held stable while `out_vld` is high and `out_rdy` is low.
  - A pop occurs when `out_vld` and `out_rdy` are both high.
- Simultaneous FIFO write and pop when full: the pop frees a slot, so the write is accepted and the level is unchanged.
- `log_clear`: same effect as reset on the FIFO, hold registers, `drop_count` and `overrun`.
  - The timestamp is not cleared.
  - Events in the clear cycle are discarded.
- Reset values:
  - `out_vld`=0, `out_data`=0, `fifo_level`=0, `drop_count`=0, `overrun`=0.
  - Timestamp=0, all hold registers invalid.
- Reset mid-transfer: the record being presented is lost; no partial state remains.

## Timing
- Latency, event to `out_vld`: event in cycle N, FIFO write in N+1 (if granted), `out_vld` in N+2 when the FIFO is empty.
- A pop in cycle P presents the next record in P+1. Sustained throughput is one record per cycle.
- `fifo_level` updates the cycle after the write or pop.
- Four simultaneous events in cycle N are written in N+1..N+4, in order src0..src3.

## Configuration
- `SIGMON_LOG_TIMESTAMP_EN` defined: timestamp counter present; [95:64] carries the event cycle count.
- Undefined: counter removed; [95:64] is always 0. All other behaviour is identical.

## Structure
- Shared package `sigmon_log_pkg` holds:
  - the record struct (field widths and offsets);
  - `SRC_W`=2, `TS_W`=32, `DATA_W`=48, `REC_W`=96;
  - the `DROP_SAT`=16'hFFFF constant.
- One sub-module, `sigmon_log_fifo`: synchronous single-clock FIFO, DEPTH x REC_W, registered output, full/empty/level, with a flush input driven by `log_clear`.

## Test plan
- **Single event:** `log_enable`=1, `src_sample`[2] pulse at timestamp 100, data 0x0000DEADBEEF → one record at N+2: ts=100, src=2, sample=1, data=0xDEADBEEF; `drop_count`=0.
- **Simultaneous events:** match on all 4 sources in one cycle (ts=50), `out_rdy`=1 → four records, src 0,1,2,3, all ts=50, on consecutive cycles.
- **Hold collision:** FIFO full, `out_rdy`=0; src0 event (held), then second src0 event → `drop_count`=1, `overrun`=1; after one pop the held record is emitted with the original timestamp.
- **Fill and drain:** DEPTH=4, inject 6 events on src1 while `out_rdy`=0.
  - Result: `fifo_level`=4, one held, one dropped.
  - Then `out_rdy`=1: 5 records in order; `fifo_level` returns to 0.
- **Clear and enable:**
  - `log_clear` with 3 queued records → `out_vld`=0 next cycle, `fifo_level`=0, `drop_count`=0.
  - Events with `log_enable`=0 → no records and no drop.
- **Backpressure and wrap:** toggle `out_rdy` randomly; `out_data` is stable while stalled. Preload the timestamp near 0xFFFFFFFE; events across the wrap show ts 0xFFFFFFFF then 0x00000000 (macro defined). Without the macro, ts=0.
